// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer
// Description : Layer-level sequencer for a streaming convolution datapath.
//               Issues lockstep reads from NUM_CH channel FIFOs for one padded
//               frame, waits for the filter datapath to produce every output
//               pixel, then steps to the next filter weight set. A watchdog
//               on the drain phase and a sticky err flag catch a stalled or
//               misbehaving datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
  parameter int WIDTH         = 112,
  parameter int NUM_CH        = 8,
  parameter int NUM_FILTERS   = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_CH-1:0]   fifo_empty,
  input  logic                out_almost_full,
  input  logic                conv_valid,
  output logic                rdreq,
  output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0] filter_idx,
  output logic                busy,
  output logic                frame_done,
  output logic                done,
  output logic                err
);

  // Frame geometry: the input frame carries a one-pixel border on each side.
  localparam int IN_TOTAL  = (WIDTH + 2) * (WIDTH + 2);
  localparam int OUT_TOTAL = WIDTH * WIDTH;
  localparam int IN_CNT_W  = $clog2(IN_TOTAL + 1);
  localparam int OUT_CNT_W = $clog2(OUT_TOTAL + 1);
  localparam int TMO_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam int FI_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(IN_TOTAL - 1);
  localparam logic [IN_CNT_W-1:0]  IN_END   = IN_CNT_W'(IN_TOTAL);
  localparam logic [OUT_CNT_W-1:0] OUT_END  = OUT_CNT_W'(OUT_TOTAL);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [FI_W-1:0]      FI_LAST  = FI_W'(NUM_FILTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [FI_W-1:0]       filter_idx_q, filter_idx_d;
  logic [IN_CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;

  logic                  w_all_ready;
  logic                  w_conv_ok;

  // All channels must hold data at once; a single empty channel stalls them all.
  assign w_all_ready = (fifo_empty == '0) && !out_almost_full;

  // A datapath output is only legal while a pass is active and still owes pixels.
  assign w_conv_ok = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (out_cnt_q != OUT_END);

  // Next-state, counter updates and decoded outputs.
  always_comb begin
    state_d      = state_q;
    filter_idx_d = filter_idx_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    rdreq        = 1'b0;
    frame_done   = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          filter_idx_d = '0;
          in_cnt_d     = '0;
          out_cnt_d    = '0;
          tmo_d        = '0;
          err_d        = 1'b0;
        end
      end

      S_RUN: begin
        rdreq = w_all_ready && (in_cnt_q < IN_END);
        if (rdreq) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (out_cnt_q == OUT_END) begin
          frame_done = 1'b1;
          if (filter_idx_q == FI_LAST) begin
            state_d = S_DONE;
          end else begin
            // Advance here so the new weight set is already selected in NEXT.
            state_d      = S_NEXT;
            filter_idx_d = filter_idx_q + 1'b1;
          end
        end else if (conv_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Datapath went silent: abandon the layer without any completion pulse.
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_NEXT: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        tmo_d     = '0;
        state_d   = S_RUN;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output pixels are counted only when expected; anything else is a protocol error.
    if (conv_valid) begin
      if (w_conv_ok) begin
        out_cnt_d = out_cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      filter_idx_q <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      filter_idx_q <= filter_idx_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
    end
  end

  assign filter_idx = filter_idx_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_sequencer
// Description : Self-checking bench for conv_layer_sequencer with a small
//               2x2 output frame and two filters. Layer-level events
//               (frame_done, done, err rising) are checked by a scoreboard;
//               cycle-level behaviour is checked directly by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

  localparam int WIDTH         = 2;
  localparam int NUM_CH        = 8;
  localparam int NUM_FILTERS   = 2;
  localparam int DRAIN_TIMEOUT = 8;
  localparam int IN_TOTAL      = 16;
  localparam int OUT_TOTAL     = 4;

  localparam int EV_FRAME = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NUM_CH-1:0] fifo_empty;
  logic              out_almost_full;
  logic              conv_valid;
  logic              rdreq;
  logic [0:0]        filter_idx;
  logic              busy;
  logic              frame_done;
  logic              done;
  logic              err;

  typedef struct {
    int kind;
    int fidx;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  rd_cnt = 0;
  logic err_prev = 1'b0;

  conv_layer_sequencer #(
    .WIDTH        (WIDTH),
    .NUM_CH       (NUM_CH),
    .NUM_FILTERS  (NUM_FILTERS),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .fifo_empty     (fifo_empty),
    .out_almost_full(out_almost_full),
    .conv_valid     (conv_valid),
    .rdreq          (rdreq),
    .filter_idx     (filter_idx),
    .busy           (busy),
    .frame_done     (frame_done),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int kind, input int fidx);
    ev_t e;
    e.kind = kind;
    e.fidx = fidx;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected record per layer-level event the DUT presents.
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
    end else if (rdreq) begin
      rd_cnt++;
    end
    if (frame_done || done || (err && !err_prev)) begin
      ev_t e;
      int kind;
      kind = frame_done ? EV_FRAME : (done ? EV_DONE : EV_ERR);
      if (exp_q.size() == 0) begin
        check("unexpected_event", kind, -1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_filter_idx", int'(filter_idx), e.fidx);
        if (kind == EV_FRAME) check("reads_per_pass", rd_cnt, IN_TOTAL);
      end
      if (kind != EV_DONE) rd_cnt = 0;
    end
    err_prev = err;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // stype: 0 = one channel empty, 1 = output almost full. Optional stray start at start_at.
  task automatic run_reads(input int n_reads, input int exp_fidx, input int s_at,
                           input int s_len, input int stype, input int start_at);
    int reads = 0;
    int i = 0;
    bit stall;
    while (reads < n_reads) begin
      stall           = (i >= s_at) && (i < s_at + s_len);
      fifo_empty      = (stall && stype == 0) ? 8'b0000_0100 : 8'b0;
      out_almost_full = stall && (stype == 1);
      start           = (i == start_at);
      #2;
      check("rdreq_run", int'(rdreq), stall ? 0 : 1);
      if (i == 0) begin
        check("busy_run", int'(busy), 1);
        check("filter_idx_run", int'(filter_idx), exp_fidx);
      end
      if (!stall) reads++;
      i++;
      cyc();
    end
    fifo_empty      = '0;
    out_almost_full = 1'b0;
    start           = 1'b0;
  endtask

  // Deliver all output pixels, then confirm frame_done and the following state.
  task automatic drain_and_finish(input bit last);
    for (int k = 0; k < OUT_TOTAL; k++) begin
      conv_valid = 1'b1;
      #2;
      check("rdreq_drain", int'(rdreq), 0);
      check("frame_done_early", int'(frame_done), 0);
      cyc();
    end
    conv_valid = 1'b0;
    #2;
    check("frame_done", int'(frame_done), 1);
    cyc();
    check("busy_after_frame", int'(busy), 1);
    if (last) begin
      check("done_pulse", int'(done), 1);
      cyc();
      check("busy_after_done", int'(busy), 0);
      check("done_cleared", int'(done), 0);
      check("filter_idx_hold", int'(filter_idx), NUM_FILTERS - 1);
    end else begin
      cyc();
    end
  endtask

  task automatic full_layer(input int s0_at, input int s0_len, input int s0_type,
                            input int s1_at, input int s1_len, input int s1_type,
                            input int start_at);
    push(EV_FRAME, 0);
    push(EV_FRAME, 1);
    push(EV_DONE, 1);
    do_start();
    check("err_after_start", int'(err), 0);
    run_reads(IN_TOTAL, 0, s0_at, s0_len, s0_type, start_at);
    drain_and_finish(1'b0);
    run_reads(IN_TOTAL, 1, s1_at, s1_len, s1_type, -1);
    drain_and_finish(1'b1);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    fifo_empty      = '0;
    out_almost_full = 1'b0;
    conv_valid      = 1'b0;
    repeat (3) cyc();
    #2;
    check("reset_rdreq", int'(rdreq), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_filter_idx", int'(filter_idx), 0);
    rst = 1'b0;
    cyc();

    // Clean two-filter layer.
    full_layer(-1, 0, 0, -1, 0, 0, -1);

    // Channel-2 empty for 3 cycles in pass 0; backpressure 5 cycles in pass 1.
    full_layer(5, 3, 0, 4, 5, 1, -1);

    // Drain watchdog: reads complete, datapath never answers.
    push(EV_ERR, 0);
    do_start();
    run_reads(IN_TOTAL, 0, -1, 0, 0, -1);
    for (int k = 0; k < DRAIN_TIMEOUT; k++) begin
      #2;
      check("err_before_timeout", int'(err), 0);
      check("busy_in_drain", int'(busy), 1);
      cyc();
    end
    #2;
    check("err_timeout", int'(err), 1);
    check("busy_after_timeout", int'(busy), 0);
    check("done_after_timeout", int'(done), 0);
    cyc();

    // Next start clears err; a stray start mid-RUN must not disturb the pass.
    full_layer(-1, 0, 0, -1, 0, 0, 3);

    // conv_valid while idle is a protocol error.
    push(EV_ERR, 1);
    conv_valid = 1'b1;
    cyc();
    conv_valid = 1'b0;
    #2;
    check("err_idle_conv", int'(err), 1);
    check("busy_idle_conv", int'(busy), 0);
    cyc();

    // Reset in the middle of a pass, with reset beating a simultaneous start.
    do_start();
    check("err_cleared_by_start", int'(err), 0);
    run_reads(9, 0, -1, 0, 0, -1);
    rst = 1'b1;
    cyc();
    #2;
    check("midrun_rst_rdreq", int'(rdreq), 0);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_err", int'(err), 0);
    check("midrun_rst_filter_idx", int'(filter_idx), 0);
    check("midrun_rst_done", int'(done), 0);
    start = 1'b1;
    cyc();
    #2;
    check("rst_beats_start", int'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    cyc();

    // A fresh start after the abort still gives a complete layer.
    full_layer(-1, 0, 0, -1, 0, 0, -1);

    repeat (2) cyc();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
